// File: rtl/pe_row_ctrl_if.sv
// pe_row_ctrl_if: weight and activation valid/ready streams
// feeding the PE row sequencing controller.
interface pe_row_ctrl_if #(
    parameter int NUM = 16
);
    logic             w_valid;
    logic             w_ready;
    logic [NUM*8-1:0] w_data;
    logic             a_valid;
    logic             a_ready;
    logic [7:0]       a_data;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready
    );
endinterface

// File: rtl/pe_row_ctrl.sv
// pe_row_ctrl: runs one PE_row tile op as
// weight load -> activation stream -> drain -> done.
module pe_row_ctrl #(
    parameter int NUM   = 16,
    parameter int ROWS  = 16,
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    pe_row_ctrl_if.slave     bus,
    output logic             pe_EN,
    output logic             pe_SELECTOR,
    output logic             pe_W_EN,
    output logic [NUM*8-1:0] pe_weight,
    output logic [7:0]       pe_active_left,
    output logic             busy,
    output logic             drain,
    output logic             done
);
    localparam int WCW = $clog2(ROWS + 1);
    localparam int DCW = $clog2(NUM + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, COMPUTE, DRAIN, DONE
    } state_t;

    state_t           state, state_nx;
    logic [WCW-1:0]   wcnt;
    logic [LEN_W-1:0] acnt;
    logic [LEN_W-1:0] len;
    logic [DCW-1:0]   dcnt;
    logic             w_hs, a_hs;
    logic             w_last, a_last, d_last;

    // ready depends on state only, never on valid
    assign bus.w_ready = (state == LOAD);
    assign bus.a_ready = (state == COMPUTE);
    assign busy        = (state != IDLE);
    assign drain       = (state == DRAIN);
    assign done        = (state == DONE);

    assign w_hs   = bus.w_valid & bus.w_ready;
    assign a_hs   = bus.a_valid & bus.a_ready;
    assign w_last = (wcnt == WCW'(ROWS - 1));
    assign a_last = (acnt == len - LEN_W'(1));
    assign d_last = (dcnt == DCW'(NUM - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (w_hs && w_last)
                         state_nx = (len == '0) ? DONE : COMPUTE;
            COMPUTE: if (a_hs && a_last) state_nx = DRAIN;
            DRAIN:   if (d_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state          <= IDLE;
            wcnt           <= '0;
            acnt           <= '0;
            dcnt           <= '0;
            len            <= '0;
            pe_EN          <= 1'b0;
            pe_SELECTOR    <= 1'b0;
            pe_W_EN        <= 1'b0;
            pe_weight      <= '0;
            pe_active_left <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len  <= vec_len;
                        wcnt <= '0;
                        acnt <= '0;
                        dcnt <= '0;
                    end
                    pe_EN          <= 1'b0;
                    pe_SELECTOR    <= 1'b0;
                    pe_W_EN        <= 1'b0;
                    pe_weight      <= '0;
                    pe_active_left <= '0;
                end
                LOAD: begin
                    if (w_hs) begin
                        pe_weight   <= bus.w_data;
                        pe_W_EN     <= 1'b1;
                        pe_SELECTOR <= 1'b1;
                        pe_EN       <= 1'b1;
                        wcnt        <= wcnt + WCW'(1);
                    end else begin
                        // weight chain must not shift on a bubble
                        pe_W_EN <= 1'b0;
                        pe_EN   <= 1'b0;
                    end
                end
                COMPUTE: begin
                    pe_SELECTOR <= 1'b0;
                    pe_W_EN     <= 1'b0;
                    if (a_hs) begin
                        pe_active_left <= bus.a_data;
                        pe_EN          <= 1'b1;
                        acnt           <= acnt + LEN_W'(1);
                    end else begin
                        pe_active_left <= '0;
                        pe_EN          <= 1'b0;
                    end
                end
                DRAIN: begin
                    pe_EN          <= 1'b1;
                    pe_active_left <= '0;
                    dcnt           <= dcnt + DCW'(1);
                end
                DONE: begin
                    pe_EN          <= 1'b0;
                    pe_SELECTOR    <= 1'b0;
                    pe_W_EN        <= 1'b0;
                    pe_weight      <= '0;
                    pe_active_left <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
